// File: rtl/wrapper_serial_paralelo.sv
// Purpose: SD CMD-line serial-to-parallel receiver; captures a 48-bit response MSB first, checks CRC7/end bit, flags NCR timeout.
// Latency: complete/parallel valid the cycle after the edge that samples the last frame bit (or the TIMEOUT-th idle sample).
// Backpressure: none on the line; results are held in DONE until enable drops, and enable must go low then high to capture again.
//
// Ports:
//   sd_clock    - receive clock, all sampling on the rising edge
//   reset       - asynchronous active-high reset
//   enable      - level request: high = receive one response, low = abort / return to idle
//   serial      - CMD line from the card (idles high)
//   parallel    - last completed frame, bit n-1 = first bit received
//   complete    - a frame or timeout result is being held
//   timeout_err - no start bit seen within TIMEOUT cycles
//   crc_err     - CRC7 over frame bits [n-1:8] differs from bits [7:1]
//   end_err     - frame bit 0 (end bit) is not 1
module wrapper_serial_paralelo #(
   parameter int n       = 48,
   parameter int TIMEOUT = 64
) (
   input  logic         sd_clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         serial,
   output logic [n-1:0] parallel,
   output logic         complete,
   output logic         timeout_err,
   output logic         crc_err,
   output logic         end_err
);

   localparam int CW = $clog2(n + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   // Index (in receive order) of the last bit of the frame and of the last
   // bit covered by the CRC (everything above the 7 CRC bits and end bit).
   localparam logic [CW-1:0] LAST_BIT     = CW'(n - 1);
   localparam logic [CW-1:0] CRC_LAST_BIT = CW'(n - 9);
   localparam logic [TW-1:0] TMO_LIMIT    = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      RECEIVE    = 2'd2,
      DONE       = 2'd3
   } state_t;

   state_t        state_q,       state_d;
   logic [n-1:0]  shift_q,       shift_d;
   logic [CW-1:0] bit_cnt_q,     bit_cnt_d;
   logic [TW-1:0] tmo_cnt_q,     tmo_cnt_d;
   logic [6:0]    crc_q,         crc_d;
   logic [n-1:0]  parallel_q,    parallel_d;
   logic          complete_q,    complete_d;
   logic          timeout_err_q, timeout_err_d;
   logic          crc_err_q,     crc_err_d;
   logic          end_err_q,     end_err_d;

   // Shift value including the bit being sampled this cycle.
   logic [n-1:0]  frame;

   // One serial step of the CRC7 LFSR, generator x^7 + x^3 + 1.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = crc[6] ^ din;
      return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
   endfunction

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;
      crc_d         = crc_q;
      parallel_d    = parallel_q;
      complete_d    = complete_q;
      timeout_err_d = timeout_err_q;
      crc_err_d     = crc_err_q;
      end_err_d     = end_err_q;
      frame         = {shift_q[n-2:0], serial};

      case (state_q)
         IDLE: begin
            if (enable) begin
               tmo_cnt_d = '0;
               crc_d     = '0;
               state_d   = WAIT_START;
            end
         end

         WAIT_START: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (!serial) begin
               // Start bit: it is a 0, so it can be skipped by the CRC.
               shift_d   = {shift_q[n-2:0], 1'b0};
               bit_cnt_d = CW'(1);
               state_d   = RECEIVE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
               if (tmo_cnt_d == TMO_LIMIT) begin
                  state_d       = DONE;
                  complete_d    = 1'b1;
                  timeout_err_d = 1'b1;
                  crc_err_d     = 1'b0;
                  end_err_d     = 1'b0;
               end
            end
         end

         RECEIVE: begin
            if (!enable) begin
               state_d = IDLE;
            end else begin
               shift_d   = frame;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q <= CRC_LAST_BIT) begin
                  crc_d = crc7_step(crc_q, serial);
               end
               // The CRC is already final here since its last bit came earlier.
               if (bit_cnt_q == LAST_BIT) begin
                  state_d       = DONE;
                  parallel_d    = frame;
                  complete_d    = 1'b1;
                  timeout_err_d = 1'b0;
                  crc_err_d     = (crc_q != frame[7:1]);
                  end_err_d     = ~frame[0];
               end
            end
         end

         DONE: begin
            if (!enable) begin
               state_d       = IDLE;
               complete_d    = 1'b0;
               timeout_err_d = 1'b0;
               crc_err_d     = 1'b0;
               end_err_d     = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sd_clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
         crc_q         <= '0;
         parallel_q    <= '0;
         complete_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         crc_err_q     <= 1'b0;
         end_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         crc_q         <= crc_d;
         parallel_q    <= parallel_d;
         complete_q    <= complete_d;
         timeout_err_q <= timeout_err_d;
         crc_err_q     <= crc_err_d;
         end_err_q     <= end_err_d;
      end
   end

   assign parallel    = parallel_q;
   assign complete    = complete_q;
   assign timeout_err = timeout_err_q;
   assign crc_err     = crc_err_q;
   assign end_err     = end_err_q;

endmodule
